// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared definitions for the ALU request arbiter:
//   - arb_state_t : controller state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - OP_*        : ALU funct3 operation codes
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational request arbiter.
//   Default build: round-robin; the search starts at ptr and wraps modulo NREQ.
//   ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr ignored.
// Ports
//   req       in   NREQ   request vector
//   ptr       in   IDW    round-robin start index (must be < NREQ)
//   en        in   1      arbitration enable; grant is zero when low
//   grant     out  NREQ   one-hot grant (or zero)
//   grant_idx out  IDW    index of the granted requester (0 when no grant)
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   pos;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        pos = k;
`else
        // ptr < NREQ, so one conditional subtract gives the modulo wrap
        pos = int'(ptr) + k;
        if (pos >= NREQ) pos = pos - NREQ;
`endif
        if (!found && req[pos]) begin
          found      = 1'b1;
          grant[pos] = 1'b1;
          grant_idx  = IDW'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one registered ALU (1-cycle latency, WIDTH+1-bit result) among NREQ
//   requesters. One operation in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   Build option: ALU_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority
//   instead of round-robin; rr_ptr does not exist in that build.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]    request handshake (ready one-hot or zero)
//   req_rs1/req_rs2 [NREQ*WIDTH]  operands, slice i = [i*WIDTH +: WIDTH]
//   req_funct3 [NREQ*3]           op select per requester
//   req_funct7 [NREQ]             op modifier per requester
//   alu_rs1/alu_rs2/alu_funct3/alu_funct7   to ALU, non-zero only in ISSUE
//   alu_rd [WIDTH+1]              from ALU, valid in WAIT
//   rsp_valid/rsp_ready           response handshake
//   rsp_id [IDW], rsp_data [WIDTH+1]  response payload, stable while in RESP
//   busy                          high whenever not IDLE
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_rs1,
  input  logic [NREQ*WIDTH-1:0] req_rs2,
  input  logic [NREQ*3-1:0]     req_funct3,
  input  logic [NREQ-1:0]       req_funct7,
  output logic [WIDTH-1:0]      alu_rs1,
  output logic [WIDTH-1:0]      alu_rs2,
  output logic [2:0]            alu_funct3,
  output logic                  alu_funct7,
  input  logic [WIDTH:0]        alu_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH:0]        rsp_data,
  output logic                  busy
);

  arb_state_t       state;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   arb_ptr;
  logic             accept;
  logic [WIDTH-1:0] sel_rs1;
  logic [WIDTH-1:0] sel_rs2;
  logic [2:0]       sel_funct3;
  logic             sel_funct7;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (arb_ptr),
    .en        (state == ST_IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready is withheld while rst is high so nothing is accepted in a reset cycle
  assign req_ready = rst ? '0 : grant;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);

  // One-hot grant mux of the winning requester's operands
  always_comb begin
    sel_rs1    = '0;
    sel_rs2    = '0;
    sel_funct3 = '0;
    sel_funct7 = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_rs1    = req_rs1[k*WIDTH +: WIDTH];
        sel_rs2    = req_rs2[k*WIDTH +: WIDTH];
        sel_funct3 = req_funct3[k*3 +: 3];
        sel_funct7 = req_funct7[k];
      end
    end
  end

  // The alu_* outputs double as the operand latches: loaded on accept, so they
  // carry the op during ISSUE, and cleared on leaving ISSUE so the ALU sees
  // rs1==0 (and holds its RD) at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_rs1    <= sel_rs1;
            alu_rs2    <= sel_rs2;
            alu_funct3 <= sel_funct3;
            alu_funct7 <= sel_funct7;
            rsp_id     <= grant_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_rs1    <= '0;
          alu_rs2    <= '0;
          alu_funct3 <= '0;
          alu_funct7 <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          rsp_data  <= alu_rd;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
//   Directed bench for alu_req_arbiter with a behavioural registered ALU.
//   Honours ALU_ARB_FIXED_PRIO_EN when the build defines it.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_rs1;
  logic [NREQ*WIDTH-1:0] req_rs2;
  logic [NREQ*3-1:0]     req_funct3;
  logic [NREQ-1:0]       req_funct7;
  logic [WIDTH-1:0]      alu_rs1;
  logic [WIDTH-1:0]      alu_rs2;
  logic [2:0]            alu_funct3;
  logic                  alu_funct7;
  logic [WIDTH:0]        alu_rd = '0;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_data;
  logic                  busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_funct3 (alu_funct3),
    .alu_funct7 (alu_funct7),
    .alu_rd     (alu_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  // Registered ALU: one-cycle latency, holds RD when RS1 is zero
  function automatic logic [WIDTH:0] alu_f(input logic [2:0] f3, input logic f7,
                                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (f3)
      OP_ADD:  alu_f = f7 ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      OP_SLL:  alu_f = {1'b0, a << b[4:0]};
      OP_SLT:  alu_f = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: alu_f = (a < b) ? 1 : 0;
      OP_XOR:  alu_f = {1'b0, a ^ b};
      OP_SRL:  alu_f = {1'b0, a >> b[4:0]};
      OP_OR:   alu_f = {1'b0, a | b};
      default: alu_f = {1'b0, a & b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_rs1 != '0) alu_rd <= alu_f(alu_funct3, alu_funct7, alu_rs1, alu_rs2);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] f3, input logic f7);
    req_rs1[i*WIDTH +: WIDTH] = a;
    req_rs2[i*WIDTH +: WIDTH] = b;
    req_funct3[i*3 +: 3]      = f3;
    req_funct7[i]             = f7;
  endtask

  // Called right after the accept edge; advances until rsp_valid or the budget runs out
  task automatic wait_rsp;
    int c;
    c = 0;
    while (!rsp_valid && c < 8) begin
      tick;
      c++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) tick;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_rs1", alu_rs1, 0);
    rst = 1'b0;
    tick;
  endtask

`ifndef ALU_ARB_FIXED_PRIO_EN
  int exp_order [5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_funct3 = '0;
    req_funct7 = '0;
    rsp_ready  = 1'b1;
    do_reset();

    // Single op with exact latency: 5 + 7
    set_req(0, 5, 7, OP_ADD, 1'b0);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    #1;
    chk("t1_issue_rs1", alu_rs1, 5);
    chk("t1_issue_rs2", alu_rs2, 7);
    chk("t1_issue_busy", busy, 1);
    chk("t1_issue_ready", req_ready, 0);
    chk("t1_issue_vld", rsp_valid, 0);
    tick;
    chk("t1_wait_rs1", alu_rs1, 0);
    chk("t1_wait_vld", rsp_valid, 0);
    tick;
    chk("t1_resp_vld", rsp_valid, 1);
    chk("t1_resp_id", rsp_id, 0);
    chk("t1_resp_data", rsp_data, 12);
    tick;
    chk("t1_done_vld", rsp_valid, 0);
    chk("t1_done_busy", busy, 0);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 100 + i, i, OP_ADD, 1'b0);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("t2_grant", req_ready, 1 << exp_order[n]);
      tick;
      wait_rsp();
      chk("t2_id", rsp_id, exp_order[n]);
      chk("t2_data", rsp_data, 100 + 2 * exp_order[n]);
      tick;
      chk("t2_single_rsp", rsp_valid, 0);
    end

    // Backpressure: pointer is now 1; 0xF0 ^ 0xFF = 0x0F
    rsp_ready = 1'b0;
    set_req(1, 32'hF0, 32'hFF, OP_XOR, 1'b0);
    #1;
    chk("t3_grant", req_ready, 4'b0010);
    tick;
    wait_rsp();
    chk("t3_id", rsp_id, 1);
    chk("t3_data", rsp_data, 32'h0F);
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("t3_hold_vld", rsp_valid, 1);
      chk("t3_hold_id", rsp_id, 1);
      chk("t3_hold_data", rsp_data, 32'h0F);
      chk("t3_hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    set_req(2, 5, 7, OP_ADD, 1'b1);
    tick;
    chk("t3_release_vld", rsp_valid, 0);
    chk("t3_next_grant", req_ready, 4'b0100);
    tick;
    wait_rsp();
    chk("t3_sub_id", rsp_id, 2);
    chk("t3_sub_data", rsp_data, 33'h1_FFFF_FFFE);
    tick;

    // Wrap: pointer is 3, only 0 and 1 request
    req_valid = 4'b0011;
    set_req(0, 32'hFFFF_FFFF, 1, OP_ADD, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 1, OP_SLT, 1'b0);
    #1;
    chk("t4_grant0", req_ready, 4'b0001);
    tick;
    wait_rsp();
    chk("t4_id0", rsp_id, 0);
    chk("t4_data0", rsp_data, 33'h1_0000_0000);
    tick;
    chk("t4_grant1", req_ready, 4'b0010);
    tick;
    wait_rsp();
    chk("t4_id1", rsp_id, 1);
    chk("t4_data1", rsp_data, 1);
    tick;

    // Reset in WAIT: pointer would be 3 after granting 2, reset returns it to 0
    req_valid = 4'b0100;
    set_req(2, 3, 4, OP_OR, 1'b0);
    #1;
    chk("t5_grant", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    tick;
    chk("t5_wait_busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_vld", rsp_valid, 0);
    chk("t5_data", rsp_data, 0);
    repeat (3) begin
      tick;
      chk("t5_no_rsp", rsp_valid, 0);
    end
    set_req(0, 1, 4, OP_SLL, 1'b0);
    req_valid = 4'b1111;
    #1;
    chk("t5_ptr_reset", req_ready, 4'b0001);
    tick;
    req_valid = '0;
    wait_rsp();
    chk("t5_id", rsp_id, 0);
    chk("t5_res", rsp_data, 16);
    tick;
`else
    // Fixed priority: requester 1 always wins over 3
    do_reset();
    set_req(1, 9, 6, OP_AND, 1'b0);
    set_req(3, 1, 1, OP_ADD, 1'b0);
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("t6_grant", req_ready, 4'b0010);
      tick;
      wait_rsp();
      chk("t6_id", rsp_id, 1);
      chk("t6_data", rsp_data, 0);
      tick;
    end
    set_req(1, 9, 6, OP_OR, 1'b0);
    #1;
    chk("t6_grant_last", req_ready, 4'b0010);
    tick;
    req_valid = '0;
    wait_rsp();
    chk("t6_or_data", rsp_data, 15);
    tick;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
